// File: rtl/issue_queue_multi_pkg.sv
// Shared types and width helpers for the multi-issue out-of-order issue queue.
package issue_pkg;

  localparam int MAX_TW = 8;

  typedef struct packed {
    logic [MAX_TW-1:0] tag;
    logic              used;
  } src_t;

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int tag_width(input int tag_count);
    return index_width(tag_count);
  endfunction

endpackage

// File: rtl/issue_queue_multi_slot.sv
// One issue-queue entry: payload, source operands and valid bit, with live readiness.
module issue_slot
  import issue_pkg::*;
#(
  parameter int DATA_WIDTH = 47,
  parameter int SRC_COUNT  = 2,
  parameter int TAG_COUNT  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic                      clr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  src_t [SRC_COUNT-1:0]      wr_src,
  input  logic [TAG_COUNT-1:0]      done_flags,
  output logic                      valid,
  output logic                      ready,
  output logic [DATA_WIDTH-1:0]     data
);

  src_t [SRC_COUNT-1:0] src;
  logic                 hit;

  always_ff @(posedge clk) begin
    if (rst || flush) valid <= 1'b0;
    else if (wr_en)   valid <= 1'b1;
    else if (clr)     valid <= 1'b0;
  end

  // Payload and sources are only meaningful while valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data <= wr_data;
      src  <= wr_src;
    end
  end

  // A tag outside 0..TAG_COUNT-1 never matches, so such a source never wakes.
  always_comb begin
    ready = valid;
    hit   = 1'b0;
    for (int s = 0; s < SRC_COUNT; s++) begin
      hit = 1'b0;
      for (int t = 0; t < TAG_COUNT; t++) begin
        if (src[s].tag == MAX_TW'(t) && done_flags[t]) hit = 1'b1;
      end
      if (src[s].used && !hit) ready = 1'b0;
    end
  end

endmodule

// File: rtl/issue_queue_multi.sv
// Out-of-order issue queue: multi-slot dispatch, age-matrix ordering, oldest-first multi-port issue.
module issue_queue_multi
  import issue_pkg::*;
#(
  parameter int DATA_WIDTH  = 47,
  parameter int PUSH_WIDTH  = 4,
  parameter int ISSUE_WIDTH = 2,
  parameter int ELEMENTS    = 8,
  parameter int SRC_COUNT   = 2,
  parameter int TAG_COUNT   = 10
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          flush,
  input  logic [DATA_WIDTH*PUSH_WIDTH-1:0]              din,
  input  logic [$clog2(TAG_COUNT)*SRC_COUNT*PUSH_WIDTH-1:0] din_src,
  input  logic [SRC_COUNT*PUSH_WIDTH-1:0]               din_src_vld,
  input  logic [$clog2(PUSH_WIDTH):0]                   din_valid_ct,
  output logic [$clog2(PUSH_WIDTH):0]                   din_ready_ct,
  input  logic [TAG_COUNT-1:0]                          done_flags,
  output logic [DATA_WIDTH*ISSUE_WIDTH-1:0]             dout,
  output logic [ISSUE_WIDTH-1:0]                        dout_valid,
  input  logic [ISSUE_WIDTH-1:0]                        dout_ready,
  output logic [$clog2(ELEMENTS):0]                     occupancy
);

  localparam int TW = tag_width(TAG_COUNT);
  localparam int CW = count_width(PUSH_WIDTH);
  localparam int OW = count_width(ELEMENTS);
  localparam int SW = index_width(PUSH_WIDTH);

  logic [ELEMENTS-1:0]   valid, ready, wr_en, clr;
  logic [DATA_WIDTH-1:0] slot_data [ELEMENTS];
  logic [DATA_WIDTH-1:0] wr_data   [ELEMENTS];
  src_t [SRC_COUNT-1:0]  wr_src    [ELEMENTS];
  src_t [SRC_COUNT-1:0]  push_src  [PUSH_WIDTH];
  logic [SW-1:0]         wr_slot   [ELEMENTS];
  logic [ELEMENTS-1:0]   age       [ELEMENTS];
  logic [ELEMENTS-1:0]   age_n     [ELEMENTS];
  logic [ELEMENTS-1:0]   pick      [ISSUE_WIDTH];
  logic [OW-1:0]         free_total, occ, issued;
  logic [CW-1:0]         push_n;

  // Source s of slot p sits at flat index p*SRC_COUNT+s.
  always_comb begin
    for (int p = 0; p < PUSH_WIDTH; p++) begin
      for (int s = 0; s < SRC_COUNT; s++) begin
        push_src[p][s].tag  = MAX_TW'(din_src[(p*SRC_COUNT+s)*TW +: TW]);
        push_src[p][s].used = din_src_vld[p*SRC_COUNT+s];
      end
    end
  end

  // Free space comes from registered valid bits, so same-cycle issues do not free slots.
  always_comb begin
    free_total = '0;
    for (int i = 0; i < ELEMENTS; i++) free_total = free_total + OW'(!valid[i]);
    if (free_total >= OW'(PUSH_WIDTH)) din_ready_ct = CW'(PUSH_WIDTH);
    else                               din_ready_ct = CW'(free_total);
    push_n = (din_valid_ct < din_ready_ct) ? din_valid_ct : din_ready_ct;
    if (flush) push_n = '0;
  end

  always_comb begin
    int rank;
    rank = 0;
    for (int i = 0; i < ELEMENTS; i++) begin
      wr_en[i]   = 1'b0;
      wr_slot[i] = '0;
      if (!valid[i]) begin
        if (rank < int'(push_n)) begin
          wr_en[i]   = 1'b1;
          wr_slot[i] = SW'(rank);
        end
        rank++;
      end
      wr_data[i] = din[int'(wr_slot[i])*DATA_WIDTH +: DATA_WIDTH];
      wr_src[i]  = push_src[wr_slot[i]];
    end
  end

  for (genvar i = 0; i < ELEMENTS; i++) begin : g_slot
    issue_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .SRC_COUNT  (SRC_COUNT),
      .TAG_COUNT  (TAG_COUNT)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .wr_en      (wr_en[i]),
      .clr        (clr[i]),
      .wr_data    (wr_data[i]),
      .wr_src     (wr_src[i]),
      .done_flags (done_flags),
      .valid      (valid[i]),
      .ready      (ready[i]),
      .data       (slot_data[i])
    );
  end

  // A new entry is younger than everything already valid; same-cycle writes order by slot.
  always_comb begin
    for (int i = 0; i < ELEMENTS; i++) begin
      for (int j = 0; j < ELEMENTS; j++) begin
        age_n[i][j] = age[i][j];
        if (wr_en[i])      age_n[i][j] = wr_en[j] && (wr_slot[i] < wr_slot[j]);
        else if (wr_en[j]) age_n[i][j] = valid[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ELEMENTS; i++) age[i] <= '0;
    end else begin
      age <= age_n;
    end
  end

  // Each port picks the ready entry that no other remaining candidate is older than.
  always_comb begin
    logic [ELEMENTS-1:0] taken, cand, older;
    taken      = '0;
    cand       = '0;
    older      = '0;
    dout       = '0;
    dout_valid = '0;
    clr        = '0;
    issued     = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      cand  = ready & ~taken;
      older = '0;
      for (int i = 0; i < ELEMENTS; i++) begin
        for (int j = 0; j < ELEMENTS; j++) begin
          if (j != i && cand[j] && age[j][i]) older[i] = 1'b1;
        end
      end
      pick[k]       = cand & ~older;
      taken         = taken | pick[k];
      dout_valid[k] = |pick[k];
      for (int i = 0; i < ELEMENTS; i++) begin
        if (pick[k][i]) dout[k*DATA_WIDTH +: DATA_WIDTH] = dout[k*DATA_WIDTH +: DATA_WIDTH] | slot_data[i];
      end
      if (dout_valid[k] && dout_ready[k]) begin
        clr    = clr | pick[k];
        issued = issued + OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) occ <= '0;
    else              occ <= occ + OW'(push_n) - issued;
  end

  assign occupancy = occ;

endmodule

// File: tb/tb_issue_queue_multi.sv
// Self-checking bench for issue_queue_multi: directed scenarios then random traffic vs an age-ordered list model.
module tb_issue_queue_multi;

  localparam int DW = 47;
  localparam int PW = 4;
  localparam int IW = 2;
  localparam int EL = 8;
  localparam int SC = 2;
  localparam int TC = 10;
  localparam int TW = 4;

  logic                clk = 1'b0;
  logic                rst, flush;
  logic [DW*PW-1:0]    din;
  logic [TW*SC*PW-1:0] din_src;
  logic [SC*PW-1:0]    din_src_vld;
  logic [2:0]          din_valid_ct;
  logic [2:0]          din_ready_ct;
  logic [TC-1:0]       done_flags;
  logic [DW*IW-1:0]    dout;
  logic [IW-1:0]       dout_valid;
  logic [IW-1:0]       dout_ready;
  logic [3:0]          occupancy;

  always #5 clk = ~clk;

  issue_queue_multi #(
    .DATA_WIDTH (DW), .PUSH_WIDTH (PW), .ISSUE_WIDTH (IW),
    .ELEMENTS (EL), .SRC_COUNT (SC), .TAG_COUNT (TC)
  ) dut (
    .clk (clk), .rst (rst), .flush (flush),
    .din (din), .din_src (din_src), .din_src_vld (din_src_vld),
    .din_valid_ct (din_valid_ct), .din_ready_ct (din_ready_ct),
    .done_flags (done_flags), .dout (dout), .dout_valid (dout_valid),
    .dout_ready (dout_ready), .occupancy (occupancy)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            tag0;
    int            tag1;
    bit            used0;
    bit            used1;
  } uop_t;

  // Model: the queue contents as a list, oldest first.
  uop_t          model_q[$];
  uop_t          stim[PW];
  int            cur_vct;
  logic [TC-1:0] cur_done;
  logic [IW-1:0] cur_rdy;
  bit            cur_flush, cur_rst;
  int            exp_idx[IW];
  logic [IW-1:0] exp_valid;
  int            exp_rct;
  int            compared   = 0;
  int            mismatched = 0;

  function automatic bit uopReady(input uop_t u, input logic [TC-1:0] df);
    return !((u.used0 && !df[u.tag0]) || (u.used1 && !df[u.tag1]));
  endfunction

  task automatic checkVal(input string name, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic setStim(input int p, input logic [DW-1:0] d, input int t0, input bit u0,
                         input int t1, input bit u1);
    stim[p].data  = d;
    stim[p].tag0  = t0;
    stim[p].used0 = u0;
    stim[p].tag1  = t1;
    stim[p].used1 = u1;
  endtask

  task automatic applyStimulus(input int vct, input logic [TC-1:0] df, input logic [IW-1:0] rdy,
                               input bit fl, input bit rs);
    cur_vct = vct; cur_done = df; cur_rdy = rdy; cur_flush = fl; cur_rst = rs;
    for (int p = 0; p < PW; p++) begin
      din[p*DW +: DW]               = stim[p].data;
      din_src[(p*SC+0)*TW +: TW]    = TW'(stim[p].tag0);
      din_src[(p*SC+1)*TW +: TW]    = TW'(stim[p].tag1);
      din_src_vld[p*SC+0]           = stim[p].used0;
      din_src_vld[p*SC+1]           = stim[p].used1;
    end
    din_valid_ct = 3'(vct);
    done_flags   = df;
    dout_ready   = rdy;
    flush        = fl;
    rst          = rs;
  endtask

  task automatic checkOutput();
    int found;
    exp_rct   = (EL - model_q.size() < PW) ? EL - model_q.size() : PW;
    exp_valid = '0;
    found     = 0;
    for (int e = 0; e < model_q.size() && found < IW; e++) begin
      if (uopReady(model_q[e], cur_done)) begin
        exp_idx[found]   = e;
        exp_valid[found] = 1'b1;
        found++;
      end
    end
    checkVal("din_ready_ct", 64'(din_ready_ct), 64'(exp_rct));
    checkVal("occupancy", 64'(occupancy), 64'(model_q.size()));
    checkVal("dout_valid", 64'(dout_valid), 64'(exp_valid));
    for (int k = 0; k < IW; k++) begin
      if (exp_valid[k]) checkVal($sformatf("dout%0d", k), 64'(dout[k*DW +: DW]), 64'(model_q[exp_idx[k]].data));
    end
  endtask

  task automatic drive(input int vct, input logic [TC-1:0] df, input logic [IW-1:0] rdy,
                       input bit fl, input bit rs);
    @(negedge clk);
    applyStimulus(vct, df, rdy, fl, rs);
    #1;
    checkOutput();
  endtask

  task automatic commit();
    int n;
    @(posedge clk);
    if (cur_rst || cur_flush) begin
      model_q.delete();
    end else begin
      n = (cur_vct < exp_rct) ? cur_vct : exp_rct;
      for (int k = IW-1; k >= 0; k--) begin
        if (exp_valid[k] && cur_rdy[k]) model_q.delete(exp_idx[k]);
      end
      for (int p = 0; p < n; p++) model_q.push_back(stim[p]);
    end
  endtask

  initial begin
    for (int p = 0; p < PW; p++) setStim(p, '0, 0, 1'b0, 0, 1'b0);
    applyStimulus(0, '0, '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);

    // Reset state
    drive(0, '0, 2'b00, 0, 0);
    checkVal("reset_occupancy", 64'(occupancy), 64'd0);
    checkVal("reset_dout_valid", 64'(dout_valid), 64'd0);
    checkVal("reset_ready_ct", 64'(din_ready_ct), 64'd4);
    commit();

    // Three source-free ops, two issue together, third follows
    setStim(0, 47'h0A0A, 0, 0, 0, 0);
    setStim(1, 47'h1B1B, 0, 0, 0, 0);
    setStim(2, 47'h2C2C, 0, 0, 0, 0);
    drive(3, '0, 2'b00, 0, 0);
    checkVal("push3_ready_ct", 64'(din_ready_ct), 64'd4);
    commit();
    drive(0, '0, 2'b11, 0, 0);
    checkVal("push3_occupancy", 64'(occupancy), 64'd3);
    checkVal("push3_valid", 64'(dout_valid), 64'b11);
    checkVal("push3_port0", 64'(dout[0 +: DW]), 64'h0A0A);
    checkVal("push3_port1", 64'(dout[DW +: DW]), 64'h1B1B);
    commit();
    drive(0, '0, 2'b01, 0, 0);
    checkVal("push3_third", 64'(dout[0 +: DW]), 64'h2C2C);
    commit();

    // Fill with entries waiting on tag 5, then wake them all at once
    for (int p = 0; p < PW; p++) setStim(p, DW'(47'h500 + p), 5, 1, 0, 0);
    drive(4, '0, 2'b00, 0, 0);
    commit();
    for (int p = 0; p < PW; p++) setStim(p, DW'(47'h510 + p), 5, 1, 0, 0);
    drive(4, '0, 2'b00, 0, 0);
    commit();
    drive(4, '0, 2'b11, 0, 0);
    checkVal("full_ready_ct", 64'(din_ready_ct), 64'd0);
    checkVal("full_valid", 64'(dout_valid), 64'd0);
    commit();
    drive(0, TC'(1 << 5), 2'b11, 0, 0);
    checkVal("wake_valid", 64'(dout_valid), 64'b11);
    checkVal("wake_oldest", 64'(dout[0 +: DW]), 64'h500);
    commit();
    repeat (3) begin
      drive(0, TC'(1 << 5), 2'b11, 0, 0);
      commit();
    end

    // Younger entry wakes first and issues ahead of the older one
    setStim(0, 47'hAAAA, 3, 1, 0, 0);
    setStim(1, 47'hBBBB, 0, 0, 4, 1);
    drive(2, '0, 2'b00, 0, 0);
    commit();
    drive(0, TC'(1 << 4), 2'b01, 0, 0);
    checkVal("ooo_b_valid", 64'(dout_valid), 64'b01);
    checkVal("ooo_b_data", 64'(dout[0 +: DW]), 64'hBBBB);
    commit();
    drive(0, TC'(1 << 3), 2'b01, 0, 0);
    checkVal("ooo_a_data", 64'(dout[0 +: DW]), 64'hAAAA);
    commit();

    // Seven valid, push four while issuing one
    for (int p = 0; p < PW; p++) setStim(p, DW'(47'h700 + p), 0, 0, 0, 0);
    drive(4, '0, 2'b00, 0, 0);
    commit();
    drive(3, '0, 2'b00, 0, 0);
    commit();
    drive(4, '0, 2'b01, 0, 0);
    checkVal("seven_ready_ct", 64'(din_ready_ct), 64'd1);
    commit();
    drive(0, '0, 2'b00, 0, 0);
    checkVal("seven_occupancy", 64'(occupancy), 64'd7);
    commit();
    drive(0, '0, 2'b00, 1, 0);
    commit();

    // Flush while pushing two with five valid
    drive(4, '0, 2'b00, 0, 0);
    commit();
    drive(1, '0, 2'b00, 0, 0);
    commit();
    drive(2, '0, 2'b11, 1, 0);
    commit();
    drive(0, '0, 2'b00, 0, 0);
    checkVal("flush_occupancy", 64'(occupancy), 64'd0);
    checkVal("flush_valid", 64'(dout_valid), 64'd0);
    commit();

    // Reset while flush and push are also active
    drive(3, '0, 2'b00, 0, 0);
    commit();
    drive(3, '0, 2'b11, 1, 1);
    commit();
    drive(0, '0, 2'b00, 0, 0);
    checkVal("rst_occupancy", 64'(occupancy), 64'd0);
    checkVal("rst_valid", 64'(dout_valid), 64'd0);
    checkVal("rst_ready_ct", 64'(din_ready_ct), 64'd4);
    commit();

    // Random traffic against the model
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [TC-1:0] df;
      for (int p = 0; p < PW; p++)
        setStim(p, DW'({$urandom(), $urandom()}), int'($urandom_range(0, TC-1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, TC-1)), 1'($urandom_range(0, 1)));
      for (int t = 0; t < TC; t++) df[t] = ($urandom_range(0, 9) < 6);
      drive(int'($urandom_range(0, PW)), df, IW'($urandom()),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
      commit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/issue_queue_multi.md
# issue_queue_multi

Parametrised out-of-order issue queue for the 6502 OoO core. It sits between rename/dispatch and the execution units. Each cycle it accepts up to PUSH_WIDTH renamed micro-ops, each carrying source tags. It wakes entries from the done_flags scoreboard vector and issues up to ISSUE_WIDTH ready entries per cycle, oldest first. A synchronous flush squashes all contents on a branch mispredict.

## Interface
Parameters:
- DATA_WIDTH, 47: payload bits per micro-op.
- PUSH_WIDTH, 4: max micro-ops accepted per cycle.
- ISSUE_WIDTH, 2: issue ports; must satisfy 1 ≤ ISSUE_WIDTH ≤ ELEMENTS.
- ELEMENTS, 8: queue depth; must be ≥ PUSH_WIDTH.
- SRC_COUNT, 2: source operands per micro-op.
- TAG_COUNT, 10: width of done_flags. TW = $clog2(TAG_COUNT).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- flush, in, 1: synchronous squash of all entries.
- din, in, DATA_WIDTH*PUSH_WIDTH: payloads; slot 0 is the oldest.
- din_src, in, TW*SRC_COUNT*PUSH_WIDTH: source tags.
- din_src_vld, in, SRC_COUNT*PUSH_WIDTH: source-used bits.
- din_valid_ct, in, $clog2(PUSH_WIDTH)+1: number of valid slots, packed from slot 0.
- din_ready_ct, out, $clog2(PUSH_WIDTH)+1: slots accepted this cycle.
- done_flags, in, TAG_COUNT: level vector; bit t set means tag t is produced.
- dout, out, DATA_WIDTH*ISSUE_WIDTH: issued payloads.
- dout_valid, out, ISSUE_WIDTH: port k holds an issuable entry.
- dout_ready, in, ISSUE_WIDTH: port k is consumed this cycle.
- occupancy, out, $clog2(ELEMENTS)+1: number of valid entries.

## Operation
- Entry state: valid bit, payload, SRC_COUNT × (tag, used).
- Entry ready = valid AND, for every used source s, done_flags[tag_s]. Ready is evaluated combinationally from the live done_flags; no wakeup latency.
- Age is tracked by an ELEMENTS×ELEMENTS age matrix: bit [i][j] = 1 means entry i is older than entry j.
  - On write, the new entry's row is set to 0 and its column is set to 1 for all valid entries.
  - Entries written in the same cycle are ordered by din slot index (slot 0 oldest).
- Selection:
  - Port 0 takes the oldest ready entry.
  - Port k takes the oldest ready entry not chosen by ports 0..k-1.
  - dout_valid[k] = 0 when fewer than k+1 entries are ready.
- Dequeue: an entry issued on port k with dout_ready[k] = 1 clears its valid bit at the next edge. With dout_valid[k] = 0, dout_ready[k] is ignored.
- din_ready_ct = min(PUSH_WIDTH, free entries). The free count is taken from registered valid bits only. Slots freed by issue in the same cycle are not reusable until the next cycle.
- Push accepts n = min(din_valid_ct, din_ready_ct) slots (0..n-1). Slot i goes to the i-th lowest free index.
- flush has priority over push and issue. All valid bits clear at the edge, and that cycle's push is dropped. dout_valid is still driven combinationally that cycle, but consumers ignore it under flush.
- rst has priority over flush. It clears valid bits and the age matrix; payload is not reset.
- Reset outputs: dout_valid = 0, occupancy = 0, din_ready_ct = min(PUSH_WIDTH, ELEMENTS). dout is don't-care while its valid bit is low.

## Timing
- Push-to-issue latency is 1 cycle: an entry written at edge N with all sources done can show dout_valid at cycle N+1.
- Wakeup-to-issue latency is 0 cycles from a done_flags rise.
- Issue-to-free latency is 1 edge. occupancy is registered: next = current + pushed − issued.
- Full: din_ready_ct = 0 and din_valid_ct is ignored.
- Empty: dout_valid = 0.
- Simultaneous push and issue in one cycle are both honoured.

## Structure
- Package issue_pkg:
  - Parameter-derived width functions (TW, count widths).
  - An src_t struct {tag, used}.
- Sub-module issue_slot, one instance per entry:
  - Holds payload, sources and the valid bit.
  - Outputs ready from done_flags.
  - Inputs: write-enable, clear, flush.
- Top level holds:
  - the age matrix;
  - the free-index allocator (prefix count over the free mask);
  - ISSUE_WIDTH cascaded oldest-ready selectors;
  - the occupancy counter.

## Test plan
- Reset, then push 3 ops with no used sources (din_valid_ct = 3) → din_ready_ct = 4 at push. Next cycle occupancy = 3 and dout_valid = 2'b11 carrying slots 0 and 1. After dout_ready = 2'b11, slot 2 appears on port 0.
- Fill ELEMENTS = 8 entries, each with src tag 5 not done → din_ready_ct = 0, dout_valid = 0. Raise done_flags[5] → dout_valid = 2'b11 the same cycle, issued oldest first.
- Entries A (older, tag 3) and B (younger, tag 4). Set done_flags[4] first → B issues. Then set done_flags[3] → A issues.
- With 7 entries valid, push 4 while issuing 1 in the same cycle → din_ready_ct = 1, and next occupancy = 7.
- Flush while pushing 2 with 5 entries valid → next cycle occupancy = 0 and dout_valid = 0; the pushed ops are dropped.
- Assert rst mid-stream while flush and push are also active → occupancy = 0, dout_valid = 0, din_ready_ct = 4 the next cycle.
